// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges a RISC-V style load/store request onto a 64-bit, doubleword-wide
// memory (Memoria64). Sub-doubleword stores are done as read-modify-write
// of the containing doubleword. Loads are extracted from the doubleword read
// and sign- or zero-extended. Misaligned or illegal requests complete without
// touching memory.
//
// Parameters
//   READ_LATENCY      cycles from o_mem_addr first driven to i_mem_rdata valid
//                     (1..3)
//
// Ports
//   i_clk             clock, all state updates on the rising edge
//   i_reset_n         synchronous reset, active low
//   i_req_valid       request present
//   o_req_ready       unit idle, request will be accepted
//   i_req_store       1 = store, 0 = load
//   i_req_funct3      RISC-V funct3 (b,h,w,d,bu,hu,wu)
//   i_req_addr        byte address
//   i_req_wdata       store data, low-order bytes used
//   o_resp_valid      one-cycle completion pulse
//   o_resp_rdata      extended load result (0 for stores and errors)
//   o_resp_misaligned completed request was misaligned
//   o_resp_illegal    completed request had an invalid funct3
//   o_mem_addr        doubleword-aligned memory address (0 when idle)
//   o_mem_wr          memory write strobe
//   o_mem_wdata       memory write data (0 when not writing)
//   i_mem_rdata       memory read data
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_store,
  input  logic [2:0]  i_req_funct3,
  input  logic [63:0] i_req_addr,
  input  logic [63:0] i_req_wdata,
  output logic        o_resp_valid,
  output logic [63:0] o_resp_rdata,
  output logic        o_resp_misaligned,
  output logic        o_resp_illegal,
  output logic [63:0] o_mem_addr,
  output logic        o_mem_wr,
  output logic [63:0] o_mem_wdata,
  input  logic [63:0] i_mem_rdata
);

  // READ lasts READ_LATENCY+1 cycles: the counter runs 0..READ_LATENCY.
  localparam logic [1:0] LAST_CNT = 2'(READ_LATENCY);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured request
  logic        r_store;
  logic [2:0]  r_funct3;
  logic [63:0] r_addr;
  logic [63:0] r_wdata;

  logic [1:0]  r_cnt;
  logic [63:0] r_buf;

  logic [63:0] r_resp_rdata;
  logic        r_resp_misaligned;
  logic        r_resp_illegal;

  logic        w_accept;
  logic        w_in_illegal;
  logic        w_in_misaligned;
  logic        w_in_error;
  logic        w_in_sd;
  logic        w_read_last;
  logic [63:0] w_buf_next;
  logic [2:0]  w_off;
  logic [63:0] w_load_shifted;
  logic [63:0] w_load_result;
  logic [7:0]  w_size_mask;
  logic [7:0]  w_store_mask;
  logic [63:0] w_store_shifted;
  logic [63:0] w_store_merged;

  // ---------------------------------------------------------------------------
  // Request classification (on the live inputs, used only at accept)
  // ---------------------------------------------------------------------------
  assign w_accept     = i_req_valid && (r_state == S_IDLE);
  assign w_in_illegal = (i_req_funct3 == 3'b111) || (i_req_store && i_req_funct3[2]);
  assign w_in_sd      = i_req_store && (i_req_funct3 == 3'b011);

  // funct3[1:0] encodes log2(size); misaligned means the low log2(size)
  // address bits are not all zero.
  always_comb begin
    w_in_misaligned = 1'b0;
    case (i_req_funct3[1:0])
      2'b01:   w_in_misaligned = i_req_addr[0];
      2'b10:   w_in_misaligned = |i_req_addr[1:0];
      2'b11:   w_in_misaligned = |i_req_addr[2:0];
      default: w_in_misaligned = 1'b0;
    endcase
  end

  assign w_in_error = w_in_illegal || w_in_misaligned;

  // ---------------------------------------------------------------------------
  // Read buffer: memory data is taken on the edge that ends the last READ
  // cycle. The load extract and response register use the next-buffer value
  // so the result is ready on that same edge.
  // ---------------------------------------------------------------------------
  assign w_read_last = (r_state == S_READ) && (r_cnt == LAST_CNT);
  assign w_buf_next  = w_read_last ? i_mem_rdata : r_buf;

  assign w_off          = r_addr[2:0];
  assign w_load_shifted = w_buf_next >> {w_off, 3'b000};

  always_comb begin
    w_load_result = w_load_shifted;
    case (r_funct3)
      3'b000:  w_load_result = {{56{w_load_shifted[7]}},  w_load_shifted[7:0]};
      3'b001:  w_load_result = {{48{w_load_shifted[15]}}, w_load_shifted[15:0]};
      3'b010:  w_load_result = {{32{w_load_shifted[31]}}, w_load_shifted[31:0]};
      3'b100:  w_load_result = {56'd0, w_load_shifted[7:0]};
      3'b101:  w_load_result = {48'd0, w_load_shifted[15:0]};
      3'b110:  w_load_result = {32'd0, w_load_shifted[31:0]};
      default: w_load_result = w_load_shifted;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store merge: byte-enable mask of the access size, moved to the byte
  // offset. Accesses are aligned, so the mask never wraps. For sd the mask is
  // all ones and the write data is the store data unchanged.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_size_mask = 8'h01;
    case (r_funct3[1:0])
      2'b00:   w_size_mask = 8'h01;
      2'b01:   w_size_mask = 8'h03;
      2'b10:   w_size_mask = 8'h0F;
      default: w_size_mask = 8'hFF;
    endcase
  end

  assign w_store_mask    = w_size_mask << w_off;
  assign w_store_shifted = r_wdata << {w_off, 3'b000};

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_merge
      assign w_store_merged[8*gi +: 8] = w_store_mask[gi] ? w_store_shifted[8*gi +: 8]
                                                          : r_buf[8*gi +: 8];
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // FSM next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_in_error) begin
            w_state_next = S_RESP;
          end else if (w_in_sd) begin
            w_state_next = S_WRITE;
          end else begin
            w_state_next = S_READ;
          end
        end
      end
      S_READ: begin
        if (w_read_last) begin
          w_state_next = r_store ? S_WRITE : S_RESP;
        end
      end
      S_WRITE: w_state_next = S_RESP;
      S_RESP:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state           <= S_IDLE;
      r_store           <= 1'b0;
      r_funct3          <= 3'd0;
      r_addr            <= 64'd0;
      r_wdata           <= 64'd0;
      r_cnt             <= 2'd0;
      r_buf             <= 64'd0;
      r_resp_rdata      <= 64'd0;
      r_resp_misaligned <= 1'b0;
      r_resp_illegal    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_buf   <= w_buf_next;
      r_cnt   <= (r_state == S_READ) ? r_cnt + 2'd1 : 2'd0;

      if (w_accept) begin
        r_store  <= i_req_store;
        r_funct3 <= i_req_funct3;
        r_addr   <= i_req_addr;
        r_wdata  <= i_req_wdata;
      end

      // Response fields change only on entry to RESP and hold until the next.
      if (w_accept && w_in_error) begin
        r_resp_rdata      <= 64'd0;
        r_resp_misaligned <= w_in_misaligned && !w_in_illegal;
        r_resp_illegal    <= w_in_illegal;
      end else if (w_read_last && !r_store) begin
        r_resp_rdata      <= w_load_result;
        r_resp_misaligned <= 1'b0;
        r_resp_illegal    <= 1'b0;
      end else if (r_state == S_WRITE) begin
        r_resp_rdata      <= 64'd0;
        r_resp_misaligned <= 1'b0;
        r_resp_illegal    <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign o_req_ready       = (r_state == S_IDLE);
  assign o_resp_valid      = (r_state == S_RESP);
  assign o_resp_rdata      = r_resp_rdata;
  assign o_resp_misaligned = r_resp_misaligned;
  assign o_resp_illegal    = r_resp_illegal;
  assign o_mem_addr        = (r_state == S_IDLE) ? 64'd0 : {r_addr[63:3], 3'b000};
  assign o_mem_wr          = (r_state == S_WRITE);
  assign o_mem_wdata       = (r_state == S_WRITE) ? w_store_merged : 64'd0;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Two instances: READ_LATENCY=1 (index 0) and READ_LATENCY=3 (index 1), each
// connected to a behavioural doubleword memory that returns poison data until
// the address has been held for READ_LATENCY cycles. A vector table covers the
// listed scenarios, hand-written sequences cover reset abort and L=3, and
// random requests are checked against a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  localparam logic [63:0] POISON = 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct packed {
    logic [63:0] rdata;
    logic        mis;
    logic        ill;
    logic [3:0]  resp_t;  // cycles after accept
    logic [3:0]  wr_t;    // 0 = no write expected
    logic [63:0] wdata;
  } exp_t;

  typedef struct packed {
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    exp_t        e;
  } vec_t;

  logic        clk;
  logic        rst_n      [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_store  [2];
  logic [2:0]  req_funct3 [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic        resp_valid [2];
  logic [63:0] resp_rdata [2];
  logic        resp_mis   [2];
  logic        resp_ill   [2];
  logic [63:0] mem_addr   [2];
  logic        mem_wr     [2];
  logic [63:0] mem_wdata  [2];
  logic [63:0] mem_rdata  [2];

  int          n_asserts = 0;
  int          n_fail    = 0;

  logic [63:0] mem [logic [63:0]];
  int          age       [2];
  bit          prev_busy [2];
  logic [63:0] last_addr [2];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      load_store_unit #(.READ_LATENCY(gi == 0 ? 1 : 3)) u_dut (
        .i_clk             (clk),
        .i_reset_n         (rst_n[gi]),
        .i_req_valid       (req_valid[gi]),
        .o_req_ready       (req_ready[gi]),
        .i_req_store       (req_store[gi]),
        .i_req_funct3      (req_funct3[gi]),
        .i_req_addr        (req_addr[gi]),
        .i_req_wdata       (req_wdata[gi]),
        .o_resp_valid      (resp_valid[gi]),
        .o_resp_rdata      (resp_rdata[gi]),
        .o_resp_misaligned (resp_mis[gi]),
        .o_resp_illegal    (resp_ill[gi]),
        .o_mem_addr        (mem_addr[gi]),
        .o_mem_wr          (mem_wr[gi]),
        .o_mem_wdata       (mem_wdata[gi]),
        .i_mem_rdata       (mem_rdata[gi])
      );
    end
  endgenerate

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  // Memory contents; untouched doublewords read as an address-derived pattern.
  function automatic logic [63:0] rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return {~a[31:0], a[31:0] ^ 32'hA5C3_96E1};
  endfunction

  // Cycles the current address has been held by a busy unit (0 = first cycle).
  function automatic int next_age(input int k);
    if (req_ready[k] !== 1'b0 || !prev_busy[k] || mem_addr[k] !== last_addr[k]) return 0;
    return age[k] + 1;
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      age[k]       <= next_age(k);
      prev_busy[k] <= (req_ready[k] === 1'b0);
      last_addr[k] <= mem_addr[k];
      mem_rdata[k] <= (req_ready[k] === 1'b0 && next_age(k) >= lat(k)) ? rd(mem_addr[k]) : POISON;
    end
  end

  // Reference model: works purely from sizes, offsets and byte arithmetic.
  function automatic exp_t model(input logic st, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] wdata,
                                 input int L);
    exp_t        e;
    int          size;
    int          off;
    logic [63:0] dw;
    logic [63:0] mask;
    logic [63:0] v;
    e    = '0;
    size = 1 << f3[1:0];
    off  = int'(addr[2:0]);
    e.ill = (f3 == 3'd7) || (st && f3[2]);
    e.mis = !e.ill && ((addr % 64'(size)) != 64'd0);
    if (e.ill || e.mis) begin
      e.resp_t = 4'd1;
      return e;
    end
    dw = rd(addr & ~64'd7);
    if (!st) begin
      v = dw >> (8 * off);
      if (size < 8) begin
        mask = (64'd1 << (8 * size)) - 64'd1;
        v    = v & mask;
        if (!f3[2] && v[8*size-1]) v = v | ~mask;
      end
      e.rdata  = v;
      e.resp_t = 4'(L + 2);
    end else if (size == 8) begin
      e.wdata  = wdata;
      e.wr_t   = 4'd1;
      e.resp_t = 4'd2;
    end else begin
      for (int b = 0; b < size; b++) dw[8*(off+b) +: 8] = wdata[8*b +: 8];
      e.wdata  = dw;
      e.wr_t   = 4'(L + 2);
      e.resp_t = 4'(L + 3);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input string what,
                     input logic [63:0] act, input logic [63:0] exp);
    n_asserts++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %h expected %h", tag, what, act, exp);
    end
  endtask

  // Issue one request on instance k (called at a negedge) and check the whole
  // transaction: timing, response fields, memory traffic and hold behaviour.
  task automatic run_req(input int k, input logic st, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata,
                         input exp_t e, input string tag);
    int          w;
    int          t;
    int          resp_t;
    int          wr_t;
    int          nwr;
    bit          got;
    bit          addr_bad;
    bit          rdy_bad;
    bit          wd_bad;
    logic [63:0] wr_addr;
    logic [63:0] wr_data;
    logic [63:0] r_data;
    logic        r_mis;
    logic        r_ill;
    req_store[k]  = st;
    req_funct3[k] = f3;
    req_addr[k]   = addr;
    req_wdata[k]  = wdata;
    req_valid[k]  = 1'b1;
    w = 0;
    while (req_ready[k] !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk(tag, "ready_before_accept", 64'(req_ready[k]), 64'd1);
    @(posedge clk);
    t = 0; got = 0; nwr = 0; resp_t = 0; wr_t = 0;
    addr_bad = 0; rdy_bad = 0; wd_bad = 0;
    wr_addr = '0; wr_data = '0; r_data = '0; r_mis = 0; r_ill = 0;
    while (!got && t < 20) begin
      @(negedge clk);
      t++;
      // Inputs while busy must be ignored.
      req_valid[k]  = 1'($urandom_range(0, 1));
      req_store[k]  = 1'($urandom_range(0, 1));
      req_funct3[k] = 3'($urandom_range(0, 7));
      req_addr[k]   = {$urandom, $urandom};
      req_wdata[k]  = {$urandom, $urandom};
      if (req_ready[k] !== 1'b0) rdy_bad = 1;
      if (mem_addr[k] !== {addr[63:3], 3'b000}) addr_bad = 1;
      if (mem_wr[k] === 1'b1) begin
        nwr++;
        wr_t    = t;
        wr_addr = mem_addr[k];
        wr_data = mem_wdata[k];
        mem[mem_addr[k]] = mem_wdata[k];
      end else if (mem_wdata[k] !== 64'd0) begin
        wd_bad = 1;
      end
      if (resp_valid[k] === 1'b1) begin
        got    = 1;
        resp_t = t;
        r_data = resp_rdata[k];
        r_mis  = resp_mis[k];
        r_ill  = resp_ill[k];
      end
    end
    req_valid[k] = 1'b0;
    chk(tag, "resp_cycle", 64'(resp_t), 64'(e.resp_t));
    chk(tag, "resp_rdata", r_data, e.rdata);
    chk(tag, "resp_misaligned", 64'(r_mis), 64'(e.mis));
    chk(tag, "resp_illegal", 64'(r_ill), 64'(e.ill));
    chk(tag, "mem_wr_count", 64'(nwr), (e.wr_t != 0) ? 64'd1 : 64'd0);
    chk(tag, "mem_wr_cycle", 64'(wr_t), 64'(e.wr_t));
    if (e.wr_t != 0) begin
      chk(tag, "mem_wdata", wr_data, e.wdata);
      chk(tag, "mem_wr_addr", wr_addr, {addr[63:3], 3'b000});
    end
    chk(tag, "mem_addr_stable", 64'(addr_bad), 64'd0);
    chk(tag, "ready_low_busy", 64'(rdy_bad), 64'd0);
    chk(tag, "wdata_zero_idle", 64'(wd_bad), 64'd0);
    @(negedge clk);
    chk(tag, "ready_after_resp", 64'(req_ready[k]), 64'd1);
    chk(tag, "resp_pulse_one", 64'(resp_valid[k]), 64'd0);
    chk(tag, "rdata_held", resp_rdata[k], e.rdata);
    $display("txn %s dut%0d st=%0d f3=%0d addr=%h wdata=%h -> rdata=%h mis=%0d ill=%0d resp@T+%0d wr@T+%0d",
             tag, k, st, f3, addr, wdata, r_data, r_mis, r_ill, resp_t, wr_t);
  endtask

  function automatic vec_t mkv(input logic st, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [63:0] rdata, input logic mis, input logic ill,
                               input int resp_t, input int wr_t, input logic [63:0] wexp);
    vec_t v;
    v.st       = st;
    v.f3       = f3;
    v.addr     = addr;
    v.wdata    = wdata;
    v.e.rdata  = rdata;
    v.e.mis    = mis;
    v.e.ill    = ill;
    v.e.resp_t = 4'(resp_t);
    v.e.wr_t   = 4'(wr_t);
    v.e.wdata  = wexp;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs [$];
    exp_t        e;
    logic        st;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    int          w;
    int          nwr;
    int          nresp;

    for (int k = 0; k < 2; k++) begin
      rst_n[k]      = 1'b0;
      req_valid[k]  = 1'b0;
      req_store[k]  = 1'b0;
      req_funct3[k] = 3'd0;
      req_addr[k]   = 64'd0;
      req_wdata[k]  = 64'd0;
    end
    mem[64'h10] = 64'h8877_6655_4433_2211;

    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset", "req_ready", 64'(req_ready[k]), 64'd1);
      chk("reset", "resp_valid", 64'(resp_valid[k]), 64'd0);
      chk("reset", "resp_rdata", resp_rdata[k], 64'd0);
      chk("reset", "resp_flags", 64'({resp_mis[k], resp_ill[k]}), 64'd0);
      chk("reset", "mem_wr", 64'(mem_wr[k]), 64'd0);
      chk("reset", "mem_addr", mem_addr[k], 64'd0);
      chk("reset", "mem_wdata", mem_wdata[k], 64'd0);
    end

    // Directed table, READ_LATENCY = 1, doubleword 0x10 = 0x8877665544332211
    vecs.push_back(mkv(0, 3'b000, 64'h17, 64'h0, 64'hFFFF_FFFF_FFFF_FF88, 0, 0, 3, 0, 64'h0));
    vecs.push_back(mkv(0, 3'b110, 64'h14, 64'h0, 64'h0000_0000_8877_6655, 0, 0, 3, 0, 64'h0));
    vecs.push_back(mkv(0, 3'b010, 64'h14, 64'h0, 64'hFFFF_FFFF_8877_6655, 0, 0, 3, 0, 64'h0));
    vecs.push_back(mkv(0, 3'b100, 64'h11, 64'h0, 64'h0000_0000_0000_0022, 0, 0, 3, 0, 64'h0));
    vecs.push_back(mkv(1, 3'b000, 64'h12, 64'hAB, 64'h0, 0, 0, 4, 3, 64'h8877_6655_44AB_2211));
    vecs.push_back(mkv(0, 3'b001, 64'h16, 64'h0, 64'hFFFF_FFFF_FFFF_8877, 0, 0, 3, 0, 64'h0));
    vecs.push_back(mkv(0, 3'b101, 64'h12, 64'h0, 64'h0000_0000_0000_44AB, 0, 0, 3, 0, 64'h0));
    vecs.push_back(mkv(1, 3'b001, 64'h13, 64'h5555, 64'h0, 1, 0, 1, 0, 64'h0));
    vecs.push_back(mkv(0, 3'b111, 64'h10, 64'h0, 64'h0, 0, 1, 1, 0, 64'h0));
    vecs.push_back(mkv(1, 3'b110, 64'h13, 64'h1234, 64'h0, 0, 1, 1, 0, 64'h0));
    vecs.push_back(mkv(1, 3'b011, 64'h18, 64'h0123_4567_89AB_CDEF, 64'h0, 0, 0, 2, 1, 64'h0123_4567_89AB_CDEF));
    vecs.push_back(mkv(0, 3'b011, 64'h18, 64'h0, 64'h0123_4567_89AB_CDEF, 0, 0, 3, 0, 64'h0));
    vecs.push_back(mkv(1, 3'b010, 64'h1C, 64'hFFFF_FFFF_DEAD_BEEF, 64'h0, 0, 0, 4, 3, 64'hDEAD_BEEF_89AB_CDEF));
    vecs.push_back(mkv(0, 3'b011, 64'h18, 64'h0, 64'hDEAD_BEEF_89AB_CDEF, 0, 0, 3, 0, 64'h0));
    vecs.push_back(mkv(0, 3'b011, 64'h14, 64'h0, 64'h0, 1, 0, 1, 0, 64'h0));
    vecs.push_back(mkv(0, 3'b011, 64'h10, 64'h0, 64'h8877_6655_44AB_2211, 0, 0, 3, 0, 64'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      run_req(0, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, vecs[i].e,
              $sformatf("vec%0d", i));
    end

    // Reset during the second READ cycle of an sb aborts it.
    req_store[0]  = 1'b1;
    req_funct3[0] = 3'b000;
    req_addr[0]   = 64'h12;
    req_wdata[0]  = 64'hCC;
    req_valid[0]  = 1'b1;
    w = 0;
    while (req_ready[0] !== 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    chk("abort", "resp_rdata_cleared", resp_rdata[0], 64'd0);
    chk("abort", "mem_addr_cleared", mem_addr[0], 64'd0);
    chk("abort", "mem_wr_cleared", 64'(mem_wr[0]), 64'd0);
    @(negedge clk);
    chk("abort", "ready_after_release", 64'(req_ready[0]), 64'd1);
    nwr = 0;
    nresp = 0;
    for (int i = 0; i < 8; i++) begin
      if (mem_wr[0] === 1'b1) nwr++;
      if (resp_valid[0] === 1'b1) nresp++;
      @(negedge clk);
    end
    chk("abort", "no_mem_wr", 64'(nwr), 64'd0);
    chk("abort", "no_resp_valid", 64'(nresp), 64'd0);
    $display("txn abort dut0 sb addr=12 reset in second READ cycle -> writes=%0d resps=%0d", nwr, nresp);
    e = '0;
    e.rdata  = 64'h8877_6655_44AB_2211;
    e.resp_t = 4'd3;
    run_req(0, 1'b0, 3'b011, 64'h10, 64'h0, e, "after_abort");

    // lb with READ_LATENCY = 3
    mem[64'h10] = 64'h8877_6655_4433_2211;
    e = '0;
    e.rdata  = 64'hFFFF_FFFF_FFFF_FF88;
    e.resp_t = 4'd5;
    run_req(1, 1'b0, 3'b000, 64'h17, 64'h0, e, "lb_L3");

    // Random requests against the reference model
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 40; i++) begin
        st    = 1'($urandom_range(0, 1));
        f3    = 3'($urandom_range(0, 7));
        addr  = 64'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) addr[63:32] = $urandom;
        wdata = {$urandom, $urandom};
        e = model(st, f3, addr, wdata, lat(k));
        run_req(k, st, f3, addr, wdata, e, $sformatf("rnd%0d_%0d", k, i));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter READ_LATENCY, default 1, meaning the number of cycles from mem_addr first being driven to mem_rdata being valid (legal values 1..3).
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 Reset  in  1  synchronous, active-low reset.
REQ-004 req_valid  in  1  datapath presents a memory request.
REQ-005 req_ready  out  1  block idle and able to accept a request.
REQ-006 req_store  in  1  1 = store, 0 = load.
REQ-007 req_funct3  in  3  RISC-V funct3: 000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu.
REQ-008 req_addr  in  64  byte address (ALUOut register value).
REQ-009 req_wdata  in  64  store data (RegB value); only the low-order bytes are used.
REQ-010 resp_valid  out  1  one-cycle completion pulse.
REQ-011 resp_rdata  out  64  extended load result.
REQ-012 resp_misaligned  out  1  the completed request was misaligned.
REQ-013 resp_illegal  out  1  the completed request had an invalid funct3.
REQ-014 mem_addr  out  64  doubleword-aligned address to Memoria64.
REQ-015 mem_wr  out  1  memory write strobe.
REQ-016 mem_wdata  out  64  memory write data.
REQ-017 mem_rdata  in  64  memory read data.

Function
REQ-018 The FSM SHALL have the states IDLE, READ, WRITE and RESP.
REQ-019 req_ready SHALL equal (state==IDLE).
REQ-020 A request SHALL be accepted only when req_valid && req_ready; all req_* inputs SHALL be captured on that edge and ignored otherwise.
REQ-021 Size SHALL be defined as b/bu=1, h/hu=2, w/wu=4, d=8 bytes. A request SHALL be misaligned when addr mod size != 0.
REQ-022 A request SHALL be illegal when funct3 is 111, or when req_store is 1 and funct3[2] is 1. Illegal SHALL take precedence over misaligned.
REQ-023 An illegal or misaligned request SHALL go IDLE->RESP. It SHALL make no memory access, and resp_rdata SHALL be 0.
REQ-024 Every load, and every store smaller than a doubleword, SHALL go IDLE->READ.
REQ-025 An aligned sd SHALL go IDLE->WRITE directly.
REQ-026 READ SHALL last exactly READ_LATENCY+1 cycles, counted by an internal counter. mem_rdata SHALL be captured into an internal buffer on the edge that ends the last READ cycle.
REQ-027 On leaving READ, a load SHALL go to RESP and a store SHALL go to WRITE.
REQ-028 In all non-IDLE states, mem_addr SHALL be {addr[63:3],3'b000} of the captured request. In IDLE it SHALL be 0.
REQ-029 mem_wr SHALL be 1 only during the single WRITE cycle. mem_wdata SHALL be 0 outside WRITE.
REQ-030 Store merge SHALL work as follows:
- off = addr[2:0].
- Bytes off..off+size-1 of the buffer are replaced by req_wdata bytes 0..size-1, little-endian.
- Other bytes are unchanged.
- For sd, mem_wdata = req_wdata.
REQ-031 Load extract SHALL compute buffer >> (8*off), keep size bytes, then sign-extend for b/h/w/d and zero-extend for bu/hu/wu.
REQ-032 RESP SHALL last one cycle with resp_valid=1, then go to IDLE.
REQ-033 resp_rdata, resp_misaligned and resp_illegal SHALL be registered, set on entry to RESP, and held until the next RESP. resp_rdata SHALL be 0 for stores.
REQ-034 Latency, with T the accept cycle and L=READ_LATENCY:
- Load: resp_valid in cycle T+L+2.
- Sub-doubleword store: mem_wr in cycle T+L+2, resp_valid in cycle T+L+3.
- sd: mem_wr in cycle T+1, resp_valid in cycle T+2.
- Error: resp_valid in cycle T+1.
REQ-035 Back-to-back operation: a new request SHALL be accepted in the cycle immediately after RESP.

Reset
REQ-036 When Reset=0 at an edge, the block SHALL enter IDLE and clear the counter, buffer, mem_wr, mem_wdata, mem_addr, resp_valid, resp_rdata, resp_misaligned and resp_illegal.
REQ-037 Reset asserted in any state, including READ or WRITE, SHALL abort the operation with no subsequent mem_wr and no resp_valid.
REQ-038 req_ready SHALL read 1 in the first cycle after Reset is released.

Verification
REQ-039 The bench SHALL cover these scenarios, with L=1 and memory doubleword 0x10 = 0x8877665544332211:
- lb 0x17 -> resp_valid at T+3, resp_rdata = 0xFFFFFFFFFFFFFF88.
- lwu 0x14 -> resp_rdata = 0x0000000088776655; lw 0x14 -> 0xFFFFFFFF88776655.
- sb 0x12, wdata 0x00000000000000AB -> a single mem_wr at T+3, mem_addr = 0x10, mem_wdata = 0x8877665544AB2211, resp_valid at T+4.
- sh 0x13 -> resp_valid at T+1, resp_misaligned = 1, no mem_wr. funct3 111 -> resp_illegal = 1.
- sd 0x18, wdata 0x0123456789ABCDEF -> mem_wr at T+1 with that data, resp_valid at T+2.
- sb accepted, Reset=0 in the second READ cycle -> no mem_wr and no resp_valid; req_ready = 1 after release. Repeat the lb scenario with L=3 -> resp_valid at T+5.
